// File: rtl/rx_sample_arbiter_pkg.sv
// Shared definitions for the receiver sample arbiter: default sample width,
// channel-index width and the serializer state encoding.
package rx_arb_pkg;

    localparam int SAMPLE_W_DEF = 24;
    localparam int CHAN_W       = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_I = 2'd1,
        SEND_Q = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rx_sample_arbiter_if.sv
// Output stream of the receiver sample arbiter: one serialized I or Q word
// per transfer, tagged with its channel index and I/Q flag.
interface rx_sample_arbiter_if #(
    parameter int SAMPLE_W = rx_arb_pkg::SAMPLE_W_DEF
);

    logic                          out_valid;
    logic                          out_ready;
    logic [SAMPLE_W-1:0]           out_data;
    logic [rx_arb_pkg::CHAN_W-1:0] out_chan;
    logic                          out_iq;

    modport master (
        output out_valid,
        output out_data,
        output out_chan,
        output out_iq,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_chan,
        input  out_iq,
        output out_ready
    );

endinterface

// File: rtl/rx_sample_arbiter_rr_pick.sv
// Round-robin picker: finds the first requesting channel starting one past
// the previous grant, wrapping modulo NRX. Purely combinational.
module rr_pick
    import rx_arb_pkg::*;
#(
    parameter int NRX = 4
) (
    input  logic [NRX-1:0]    req,
    input  logic [CHAN_W-1:0] last_grant,
    output logic              any,
    output logic [CHAN_W-1:0] grant
);

    logic [7:0]        req_ext_s;
    logic [CHAN_W-1:0] cand_s;

    // Walk the channels in rotated order and keep the first requester.
    always_comb begin
        req_ext_s = 8'(req);
        any       = 1'b0;
        grant     = 3'd0;
        cand_s    = 3'd0;
        for (int i = 0; i < NRX; i++) begin
            cand_s = CHAN_W'((32'(last_grant) + 32'(i) + 32'd1) % 32'(NRX));
            if (!any && req_ext_s[cand_s]) begin
                any   = 1'b1;
                grant = cand_s;
            end else begin
                any   = any;
            end
        end
    end

endmodule

// File: rtl/rx_sample_arbiter.sv
// Receiver sample arbiter: buffers one I/Q pair per channel and serializes
// pending pairs onto a single valid/ready stream (I word then Q word),
// choosing channels round-robin. Sticky per-channel overflow flags record
// samples overwritten before they were granted.
// Optional feature: define RX_ARB_OVF_COUNT_EN to add a saturating 16-bit
// overflow event counter on port ovf_count.
module rx_sample_arbiter
    import rx_arb_pkg::*;
#(
    parameter int NRX      = 4,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic [NRX-1:0]          rx_strobe,
    input  logic [NRX*SAMPLE_W-1:0] rx_data_I,
    input  logic [NRX*SAMPLE_W-1:0] rx_data_Q,
    input  logic                    ovf_clear,
    output logic [NRX-1:0]          ovf,
`ifdef RX_ARB_OVF_COUNT_EN
    output logic [15:0]             ovf_count,
`endif
    rx_sample_arbiter_if.master     out_if
);

    localparam int IDX_W = (NRX > 1) ? $clog2(NRX) : 1;

    // Per-channel hold buffers
    logic [SAMPLE_W-1:0] buf_i_r [NRX];
    logic [SAMPLE_W-1:0] buf_q_r [NRX];
    logic [NRX-1:0]      pend_r;
    logic [NRX-1:0]      ovf_r;

    // Serializer state and registered outputs
    arb_state_e          state_r;
    logic [CHAN_W-1:0]   last_grant_r;
    logic                out_valid_r;
    logic [SAMPLE_W-1:0] out_data_r;
    logic [SAMPLE_W-1:0] q_hold_r;
    logic [CHAN_W-1:0]   out_chan_r;
    logic                out_iq_r;

    // Grant decode
    logic                any_s;
    logic [CHAN_W-1:0]   grant_s;
    logic [IDX_W-1:0]    grant_idx_s;
    logic                grant_fire_s;
    logic [NRX-1:0]      grant_vec_s;
    logic [NRX-1:0]      ovf_evt_s;

    rr_pick #(
        .NRX        (NRX)
    ) u_rr_pick (
        .req        (pend_r),
        .last_grant (last_grant_r),
        .any        (any_s),
        .grant      (grant_s)
    );

    // Decode this cycle's grant and the overflow events it does not cover.
    always_comb begin
        grant_idx_s  = grant_s[IDX_W-1:0];
        grant_fire_s = (state_r == IDLE) && any_s;
        grant_vec_s  = {NRX{1'b0}};
        ovf_evt_s    = {NRX{1'b0}};
        for (int k = 0; k < NRX; k++) begin
            grant_vec_s[k] = grant_fire_s && (grant_s == CHAN_W'(k));
            ovf_evt_s[k]   = rx_strobe[k] && pend_r[k] && !grant_vec_s[k];
        end
    end

    // Hold buffers, pending bits and sticky overflow flags.
    always_ff @(posedge clock) begin
        if (rst) begin
            pend_r <= {NRX{1'b0}};
            ovf_r  <= {NRX{1'b0}};
            for (int k = 0; k < NRX; k++) begin
                buf_i_r[k] <= {SAMPLE_W{1'b0}};
                buf_q_r[k] <= {SAMPLE_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < NRX; k++) begin
                if (rx_strobe[k]) begin
                    // A strobe always refreshes the buffer; it re-arms pending
                    // even when the old contents are being granted this edge.
                    buf_i_r[k] <= rx_data_I[k*SAMPLE_W +: SAMPLE_W];
                    buf_q_r[k] <= rx_data_Q[k*SAMPLE_W +: SAMPLE_W];
                    pend_r[k]  <= 1'b1;
                end else if (grant_vec_s[k]) begin
                    pend_r[k]  <= 1'b0;
                end else begin
                    pend_r[k]  <= pend_r[k];
                end
            end
            // A fresh overflow beats a simultaneous clear.
            ovf_r <= (ovf_clear ? {NRX{1'b0}} : ovf_r) | ovf_evt_s;
        end
    end

    // Serializer FSM: grant in IDLE, then emit the I word and the Q word.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= CHAN_W'(NRX - 1);
            out_valid_r  <= 1'b0;
            out_data_r   <= {SAMPLE_W{1'b0}};
            q_hold_r     <= {SAMPLE_W{1'b0}};
            out_chan_r   <= 3'd0;
            out_iq_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        out_valid_r  <= 1'b1;
                        out_data_r   <= buf_i_r[grant_idx_s];
                        q_hold_r     <= buf_q_r[grant_idx_s];
                        out_chan_r   <= grant_s;
                        out_iq_r     <= 1'b0;
                        last_grant_r <= grant_s;
                        state_r      <= SEND_I;
                    end else begin
                        out_valid_r  <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                SEND_I: begin
                    if (out_if.out_ready) begin
                        out_data_r <= q_hold_r;
                        out_iq_r   <= 1'b1;
                        state_r    <= SEND_Q;
                    end else begin
                        state_r    <= SEND_I;
                    end
                end
                SEND_Q: begin
                    if (out_if.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= SEND_Q;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign out_if.out_valid = out_valid_r;
    assign out_if.out_data  = out_data_r;
    assign out_if.out_chan  = out_chan_r;
    assign out_if.out_iq    = out_iq_r;
    assign ovf              = ovf_r;

`ifdef RX_ARB_OVF_COUNT_EN
    logic [15:0] ovf_count_r;

    // Add the number of overflow events this edge to base, saturating.
    function automatic logic [15:0] sat_add_events(
        input logic [15:0]    base,
        input logic [NRX-1:0] evt
    );
        logic [16:0] sum;
        sum = {1'b0, base};
        for (int k = 0; k < NRX; k++) begin
            sum = sum + {16'd0, evt[k]};
        end
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Overflow event counter; a same-edge overflow still counts after a clear.
    always_ff @(posedge clock) begin
        if (rst) begin
            ovf_count_r <= 16'd0;
        end else begin
            ovf_count_r <= sat_add_events(ovf_clear ? 16'd0 : ovf_count_r, ovf_evt_s);
        end
    end

    assign ovf_count = ovf_count_r;
`endif

endmodule

// File: tb/tb_rx_sample_arbiter.sv
// Directed self-checking bench for rx_sample_arbiter (NRX=4, SAMPLE_W=24).
module tb_rx_sample_arbiter;

    localparam int NRX = 4;
    localparam int SW  = 24;

    logic              clk;
    logic              rst;
    logic [NRX-1:0]    rx_strobe;
    logic [NRX*SW-1:0] rx_data_I;
    logic [NRX*SW-1:0] rx_data_Q;
    logic              ovf_clear;
    logic [NRX-1:0]    ovf;
`ifdef RX_ARB_OVF_COUNT_EN
    logic [15:0]       ovf_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    rx_sample_arbiter_if #(.SAMPLE_W(SW)) out_if ();

    rx_sample_arbiter #(
        .NRX       (NRX),
        .SAMPLE_W  (SW)
    ) dut (
        .clock     (clk),
        .rst       (rst),
        .rx_strobe (rx_strobe),
        .rx_data_I (rx_data_I),
        .rx_data_Q (rx_data_Q),
        .ovf_clear (ovf_clear),
        .ovf       (ovf),
`ifdef RX_ARB_OVF_COUNT_EN
        .ovf_count (ovf_count),
`endif
        .out_if    (out_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rx_strobe = 4'b0000;
        ovf_clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_chan(input int k, input logic [23:0] iv, input logic [23:0] qv);
        rx_data_I[k*SW +: SW] = iv;
        rx_data_Q[k*SW +: SW] = qv;
    endtask

    task automatic check_word(input string tag, input int ch, input logic iq, input logic [23:0] d);
        check_val({tag, "_valid"}, 32'(out_if.out_valid), 32'd1);
        check_val({tag, "_chan"},  32'(out_if.out_chan),  32'(ch));
        check_val({tag, "_iq"},    32'(out_if.out_iq),    32'(iq));
        check_val({tag, "_data"},  32'(out_if.out_data),  32'(d));
    endtask

    logic [23:0] exp_i [4];
    logic [23:0] exp_q [4];

    initial begin
        rst              = 1'b1;
        rx_strobe        = 4'b0000;
        rx_data_I        = '0;
        rx_data_Q        = '0;
        ovf_clear        = 1'b0;
        out_if.out_ready = 1'b0;

        // Reset state
        do_reset();
        check_val("rst_valid", 32'(out_if.out_valid), 32'd0);
        check_val("rst_data",  32'(out_if.out_data),  32'd0);
        check_val("rst_chan",  32'(out_if.out_chan),  32'd0);
        check_val("rst_iq",    32'(out_if.out_iq),    32'd0);
        check_val("rst_ovf",   32'(ovf),              32'd0);

        // Single strobe on ch2, latency t+2
        out_if.out_ready = 1'b1;
        set_chan(2, 24'h000123, 24'hFFFEDC);
        rx_strobe = 4'b0100;
        tick();
        rx_strobe = 4'b0000;
        check_val("single_t1_valid", 32'(out_if.out_valid), 32'd0);
        tick();
        check_word("single_i", 2, 1'b0, 24'h000123);
        tick();
        check_word("single_q", 2, 1'b1, 24'hFFFEDC);
        tick();
        check_val("single_idle_valid", 32'(out_if.out_valid), 32'd0);
        check_val("single_ovf", 32'(ovf), 32'd0);

        // All four channels at once: ch0..ch3, 3 cycles each
        do_reset();
        out_if.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_i[k] = 24'h100000 + 24'(k);
            exp_q[k] = 24'h200000 + 24'(k);
            set_chan(k, exp_i[k], exp_q[k]);
        end
        rx_strobe = 4'b1111;
        tick();
        rx_strobe = 4'b0000;
        tick();
        for (int k = 0; k < 4; k++) begin
            check_word("all_i", k, 1'b0, exp_i[k]);
            tick();
            check_word("all_q", k, 1'b1, exp_q[k]);
            tick();
            check_val("all_idle_valid", 32'(out_if.out_valid), 32'd0);
            tick();
        end
        check_val("all_ovf", 32'(ovf), 32'd0);

        // Backpressure in SEND_I for 10 cycles
        do_reset();
        out_if.out_ready = 1'b0;
        set_chan(1, 24'hABCDEF, 24'h123456);
        rx_strobe = 4'b0010;
        tick();
        rx_strobe = 4'b0000;
        tick();
        for (int c = 0; c < 10; c++) begin
            check_word("hold_i", 1, 1'b0, 24'hABCDEF);
            tick();
        end
        check_word("hold_i_end", 1, 1'b0, 24'hABCDEF);
        out_if.out_ready = 1'b1;
        tick();
        check_word("hold_q", 1, 1'b1, 24'h123456);
        tick();
        check_val("hold_idle_valid", 32'(out_if.out_valid), 32'd0);

        // Overflow: two strobes on ch1 while ch0 holds the bus
        do_reset();
        out_if.out_ready = 1'b0;
        set_chan(0, 24'h0A0A0A, 24'h0B0B0B);
        rx_strobe = 4'b0001;
        tick();
        rx_strobe = 4'b0000;
        tick();
        set_chan(1, 24'hA1A1A1, 24'hB1B1B1);
        rx_strobe = 4'b0010;
        tick();
        check_word("ovf_ch0_hold", 0, 1'b0, 24'h0A0A0A);
        set_chan(1, 24'hA2A2A2, 24'hB2B2B2);
        rx_strobe = 4'b0010;
        tick();
        rx_strobe = 4'b0000;
        check_val("ovf_flag", 32'(ovf), 32'h2);
        out_if.out_ready = 1'b1;
        tick();
        check_word("ovf_ch0_q", 0, 1'b1, 24'h0B0B0B);
        tick();
        tick();
        check_word("ovf_ch1_i", 1, 1'b0, 24'hA2A2A2);
        tick();
        check_word("ovf_ch1_q", 1, 1'b1, 24'hB2B2B2);
        tick();
        check_val("ovf_idle_valid", 32'(out_if.out_valid), 32'd0);
        check_val("ovf_sticky", 32'(ovf), 32'h2);
`ifdef RX_ARB_OVF_COUNT_EN
        check_val("ovf_count_1", 32'(ovf_count), 32'd1);
`endif
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check_val("ovf_cleared", 32'(ovf), 32'd0);
`ifdef RX_ARB_OVF_COUNT_EN
        check_val("ovf_count_clr", 32'(ovf_count), 32'd0);
`endif

        // Strobe on the grant edge re-arms pending without overflow; a strobe
        // during the send leaves the output words alone
        do_reset();
        out_if.out_ready = 1'b1;
        set_chan(3, 24'h000031, 24'h000032);
        rx_strobe = 4'b1000;
        tick();
        set_chan(3, 24'h000033, 24'h000034);
        rx_strobe = 4'b1000;
        tick();
        rx_strobe = 4'b0000;
        check_word("regrant_i1", 3, 1'b0, 24'h000031);
        check_val("regrant_ovf", 32'(ovf), 32'd0);
        tick();
        check_word("regrant_q1", 3, 1'b1, 24'h000032);
        tick();
        check_val("regrant_idle", 32'(out_if.out_valid), 32'd0);
        tick();
        check_word("regrant_i2", 3, 1'b0, 24'h000033);
        set_chan(3, 24'h000037, 24'h000038);
        rx_strobe = 4'b1000;
        tick();
        rx_strobe = 4'b0000;
        check_word("regrant_q2", 3, 1'b1, 24'h000034);
        tick();
        tick();
        check_word("regrant_i3", 3, 1'b0, 24'h000037);
        tick();
        check_word("regrant_q3", 3, 1'b1, 24'h000038);
        check_val("regrant_ovf_end", 32'(ovf), 32'd0);

        // Clear and overflow on the same edge: overflow wins
        do_reset();
        out_if.out_ready = 1'b0;
        rx_strobe = 4'b0001;
        tick();
        rx_strobe = 4'b0000;
        tick();
        rx_strobe = 4'b0100;
        tick();
        rx_strobe = 4'b0100;
        tick();
        check_val("race_ovf_set", 32'(ovf), 32'h4);
        rx_strobe = 4'b0100;
        ovf_clear = 1'b1;
        tick();
        rx_strobe = 4'b0000;
        check_val("race_ovf_wins", 32'(ovf), 32'h4);
`ifdef RX_ARB_OVF_COUNT_EN
        check_val("race_count", 32'(ovf_count), 32'd1);
`endif
        tick();
        ovf_clear = 1'b0;
        check_val("race_cleared", 32'(ovf), 32'd0);

        // Reset in SEND_Q with ch3 pending; strobes during reset ignored
        do_reset();
        out_if.out_ready = 1'b1;
        set_chan(0, 24'h0C0C0C, 24'h0D0D0D);
        set_chan(3, 24'h3C3C3C, 24'h3D3D3D);
        rx_strobe = 4'b1001;
        tick();
        rx_strobe = 4'b0000;
        tick();
        check_word("mid_i", 0, 1'b0, 24'h0C0C0C);
        tick();
        check_word("mid_q", 0, 1'b1, 24'h0D0D0D);
        rst       = 1'b1;
        rx_strobe = 4'b0010;
        tick();
        rst       = 1'b0;
        rx_strobe = 4'b0000;
        check_val("mid_rst_valid", 32'(out_if.out_valid), 32'd0);
        check_val("mid_rst_ovf",   32'(ovf),              32'd0);
        check_val("mid_rst_data",  32'(out_if.out_data),  32'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            check_val("mid_no_output", 32'(out_if.out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
